ec_point_add_dbl: RTL and testbench
===================================

// Module: ec_point_add_dbl
// PURPOSE
//  Parametrised affine short-Weierstrass point unit: computes R = P + Q mod PRIME, switching to doubling when P == Q.
//  Handles the point at infinity via explicit flags, and P == -Q. Uses a start/done handshake.
//  Reuses one field multiplier and one modular_inverse, sequenced by an FSM.
//  Sits beneath the MSM bucket accumulator, replacing the fixed 256-bit add-only adder.
// PARAMETERS
//  WIDTH  256  field element width in bits
//  PRIME  secp256k1 p  field modulus; WIDTH bits, odd, > 3
//  A_COEF 0    curve coefficient a in y^2 = x^3 + a*x + b; used only in doubling
// PORTS
//  clk    in   1      clock, rising edge
//  Reset  in   1      synchronous, active-high
//  start  in   1      request; sampled only when ready = 1
//  ready  out  1      block idle, accepts start
//  Px,Py  in   WIDTH  operand P, captured on accepted start, each < PRIME
//  P_inf  in   1      P is the point at infinity; Px/Py ignored
//  Qx,Qy  in   WIDTH  operand Q, captured on accepted start
//  Q_inf  in   1      Q is the point at infinity
//  Done   out  1      one-cycle pulse; result valid
//  Rx,Ry  out  WIDTH  result, held from Done until the next accepted start
//  R_inf  out  1      result is the point at infinity
//  dbl    out  1      result came from the doubling path; qualified by Done
// BEHAVIOUR
//  Reset: FSM -> IDLE; ready=1; Done=0; Rx=Ry=0; R_inf=0; dbl=0. Sub-units are held in reset.
//  Reset mid-operation aborts the job. No Done is issued. ready=1 the cycle after Reset drops.
//  start with ready=0 is ignored and not queued. Inputs are registered at accept; later input changes have no effect.
//  Field arithmetic: add/sub use a WIDTH+1 bit intermediate with one conditional correction by PRIME.
//   All internal values stay in [0, PRIME).
//  States: IDLE -> CLASS (1 cycle, classify) -> one of the following paths:
//   CLASS, P_inf: R = Q (including Q_inf) -> FIN.
//   CLASS, Q_inf only: R = P -> FIN.
//   CLASS, Px == Qx and (Py != Qy or Py == 0): R_inf = 1 -> FIN.
//   CLASS, Px == Qx and Py == Qy: doubling. SQX (x^2) -> INV (1/(2y)) -> MUL_S (s = (3x^2 + a) * inv).
//   CLASS, otherwise: add. INV (1/(Px - Qx)) -> MUL_S (s = (Py - Qy) * inv).
//   Both paths then run MUL_S2 (s^2; Rx = s^2 - Px - Qx) -> MUL_Y (Ry = s*(Px - Rx) - Py) -> FIN.
//  Doubling uses Qx = Px in the Rx formula.
//  Sub-unit sequencing: a sub-unit's Reset is released on entry to its state and reasserted on exit.
//   Its operands are registered and stable while released.
//   Its Done is sampled on the clock edge and advances the state in that same edge.
//  FIN: Rx/Ry/R_inf/dbl are registered and Done=1 for exactly one cycle; then IDLE, ready=1.
//  Latency: special cases take 3 cycles from start to Done. Arithmetic paths take 3 + sum of sub-unit latencies + 1 per state transition.
//  ready=0 from the cycle after accept through the FIN cycle. Back-to-back start is allowed in the cycle after FIN.
//  Inputs >= PRIME are out of contract; no checking is done.
// TESTING
//  (All cases use WIDTH=8, PRIME=17, A_COEF=2; curve y^2 = x^3 + 2x + 2; G = (5,1).)
//  1. P=(5,1), Q=(5,1) -> Done with R=(6,3), dbl=1, R_inf=0.
//  2. P=(5,1), Q=(6,3) -> R=(10,6), dbl=0. Then back-to-back with P=(6,3), Q=(6,3) -> R=(3,1).
//  3. P=(5,1), Q=(5,16) -> R_inf=1, 3 cycles after start. Also P_inf=1, Q=(6,3) -> R=(6,3). Also P_inf=Q_inf=1 -> R_inf=1.
//  4. Assert Reset 2 cycles into the job for 1 cycle -> no Done, ready=1, outputs 0. Next start P=(5,1), Q=(6,3) -> R=(10,6).
//  5. Pulse start while busy with different operands -> ignored; first job's result is unchanged.
//     Operand changes after accept do not alter the result.
//  6. Randomised: 500 pairs of points from the subgroup of G (order 19) -> R matches a software model. Done is a single-cycle pulse.

Source files
------------

// File: rtl/ec_point_add_dbl.sv
// Affine short-Weierstrass point add/double over GF(PRIME), sequenced around one
// shared field multiplier and one binary-Euclid inverter.

module ec_fmul #(
  parameter int              WIDTH = 256,
  parameter logic [WIDTH-1:0] PRIME = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[WIDTH-1:0];
  endfunction

  // MSB-first interleaved multiply: acc = 2*acc + bit*b, reduced after each add.
  always_ff @(posedge clk) begin
    if (rst) begin
      res  <= '0;
      a_sh <= a;
      b_r  <= b;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!done) begin
      res  <= mod_add(mod_add(res, res), a_sh[WIDTH-1] ? b_r : '0);
      a_sh <= a_sh << 1;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) done <= 1'b1;
    end
  end
endmodule

module ec_finv #(
  parameter int              WIDTH = 256,
  parameter logic [WIDTH-1:0] PRIME = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH-1:0] u, v, x1, x2;

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, PRIME};
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, PRIME}) : {1'b0, x};
    return t[WIDTH:1];
  endfunction

  // Invariants: x1*a == u and x2*a == v (mod PRIME); one reduction step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      u    <= a;
      v    <= PRIME;
      x1   <= WIDTH'(1);
      x2   <= '0;
      res  <= '0;
      done <= 1'b0;
    end else if (!done) begin
      if (u == WIDTH'(1)) begin
        res  <= x1;
        done <= 1'b1;
      end else if (v == WIDTH'(1)) begin
        res  <= x2;
        done <= 1'b1;
      end else if (u == '0) begin
        res  <= '0;
        done <= 1'b1;
      end else if (!u[0]) begin
        u  <= u >> 1;
        x1 <= half(x1);
      end else if (!v[0]) begin
        v  <= v >> 1;
        x2 <= half(x2);
      end else if (u >= v) begin
        u  <= u - v;
        x1 <= mod_sub(x1, x2);
      end else begin
        v  <= v - u;
        x2 <= mod_sub(x2, x1);
      end
    end
  end
endmodule

module ec_point_add_dbl #(
  parameter int              WIDTH  = 256,
  parameter logic [WIDTH-1:0] PRIME  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [WIDTH-1:0] A_COEF = '0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] Px,
  input  logic [WIDTH-1:0] Py,
  input  logic             P_inf,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  input  logic             Q_inf,
  output logic             Done,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry,
  output logic             R_inf,
  output logic             dbl
);
  localparam logic [WIDTH-1:0] A_RED = A_COEF % PRIME;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASS, S_SQX, S_INV, S_MUL_S, S_MUL_S2, S_MUL_Y, S_FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] px_r, py_r, qx_r, qy_r;
  logic             pinf_r, qinf_r, is_dbl;
  logic [WIDTH-1:0] t_sq, s_r, w_rx, w_ry;
  logic             w_rinf;
  logic [WIDTH-1:0] mul_a, mul_b, inv_a;
  logic             mul_rst, inv_rst;
  logic             mul_done, inv_done;
  logic [WIDTH-1:0] mul_res, inv_res;
  logic [WIDTH-1:0] rx_calc, num_dbl;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, PRIME}) s = s - {1'b0, PRIME};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, PRIME};
    return d[WIDTH-1:0];
  endfunction

  logic mul_rst_w, inv_rst_w;
  assign mul_rst_w = Reset | mul_rst;
  assign inv_rst_w = Reset | inv_rst;

  ec_fmul #(.WIDTH(WIDTH), .PRIME(PRIME)) u_mul (
    .clk(clk), .rst(mul_rst_w), .a(mul_a), .b(mul_b), .done(mul_done), .res(mul_res)
  );

  ec_finv #(.WIDTH(WIDTH), .PRIME(PRIME)) u_inv (
    .clk(clk), .rst(inv_rst_w), .a(inv_a), .done(inv_done), .res(inv_res)
  );

  always_comb begin
    rx_calc = mod_sub(mod_sub(mul_res, px_r), qx_r);
    num_dbl = mod_add(mod_add(mod_add(t_sq, t_sq), t_sq), A_RED);
  end

  // Each sub-unit spends its first cycle in a state held in reset, loading its operands.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      Done    <= 1'b0;
      Rx      <= '0;
      Ry      <= '0;
      R_inf   <= 1'b0;
      dbl     <= 1'b0;
      mul_rst <= 1'b1;
      inv_rst <= 1'b1;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          px_r   <= Px;
          py_r   <= Py;
          qx_r   <= Qx;
          qy_r   <= Qy;
          pinf_r <= P_inf;
          qinf_r <= Q_inf;
          ready  <= 1'b0;
          state  <= S_CLASS;
        end
        S_CLASS: begin
          is_dbl <= 1'b0;
          w_rinf <= 1'b0;
          if (pinf_r) begin
            w_rx   <= qx_r;
            w_ry   <= qy_r;
            w_rinf <= qinf_r;
            state  <= S_FIN;
          end else if (qinf_r) begin
            w_rx  <= px_r;
            w_ry  <= py_r;
            state <= S_FIN;
          end else if (px_r == qx_r && (py_r != qy_r || py_r == '0)) begin
            w_rx   <= '0;
            w_ry   <= '0;
            w_rinf <= 1'b1;
            state  <= S_FIN;
          end else if (px_r == qx_r) begin
            is_dbl <= 1'b1;
            mul_a  <= px_r;
            mul_b  <= px_r;
            state  <= S_SQX;
          end else begin
            inv_a <= mod_sub(px_r, qx_r);
            state <= S_INV;
          end
        end
        S_SQX: begin
          if (mul_rst) mul_rst <= 1'b0;
          else if (mul_done) begin
            t_sq    <= mul_res;
            mul_rst <= 1'b1;
            inv_a   <= mod_add(py_r, py_r);
            state   <= S_INV;
          end
        end
        S_INV: begin
          if (inv_rst) inv_rst <= 1'b0;
          else if (inv_done) begin
            inv_rst <= 1'b1;
            mul_a   <= is_dbl ? num_dbl : mod_sub(py_r, qy_r);
            mul_b   <= inv_res;
            state   <= S_MUL_S;
          end
        end
        S_MUL_S: begin
          if (mul_rst) mul_rst <= 1'b0;
          else if (mul_done) begin
            s_r     <= mul_res;
            mul_a   <= mul_res;
            mul_b   <= mul_res;
            mul_rst <= 1'b1;
            state   <= S_MUL_S2;
          end
        end
        S_MUL_S2: begin
          if (mul_rst) mul_rst <= 1'b0;
          else if (mul_done) begin
            w_rx    <= rx_calc;
            mul_a   <= s_r;
            mul_b   <= mod_sub(px_r, rx_calc);
            mul_rst <= 1'b1;
            state   <= S_MUL_Y;
          end
        end
        S_MUL_Y: begin
          if (mul_rst) mul_rst <= 1'b0;
          else if (mul_done) begin
            w_ry    <= mod_sub(mul_res, py_r);
            mul_rst <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_FIN: begin
          Rx    <= w_rx;
          Ry    <= w_ry;
          R_inf <= w_rinf;
          dbl   <= is_dbl;
          Done  <= 1'b1;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ec_point_add_dbl.sv
// Directed vector table plus reset/busy sequences and a random sweep over the
// order-19 subgroup of y^2 = x^3 + 2x + 2 over GF(17).

module tb_ec_point_add_dbl;
  logic       clk = 1'b0;
  logic       Reset, start, ready, P_inf, Q_inf, Done, R_inf, dbl;
  logic [7:0] Px, Py, Qx, Qy, Rx, Ry;

  int total = 0;
  int bad   = 0;

  ec_point_add_dbl #(.WIDTH(8), .PRIME(8'd17), .A_COEF(8'd2)) dut (
    .clk(clk), .Reset(Reset), .start(start), .ready(ready),
    .Px(Px), .Py(Py), .P_inf(P_inf), .Qx(Qx), .Qy(Qy), .Q_inf(Q_inf),
    .Done(Done), .Rx(Rx), .Ry(Ry), .R_inf(R_inf), .dbl(dbl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pi, px, py, qi, qx, qy;
    int ei, ex, ey, ed, lat;
  } vec_t;

  vec_t vecs[8];
  int   ptx[$];
  int   pty[$];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic int fm(input int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int finv(input int a);
    int r = 1;
    for (int i = 0; i < 15; i++) r = fm(r * a);
    return r;
  endfunction

  task automatic model(input int pi, px, py, qi, qx, qy,
                       output int ri, rx, ry, rd);
    int s;
    ri = 0; rx = 0; ry = 0; rd = 0;
    if (pi != 0) begin
      ri = qi; rx = qx; ry = qy;
    end else if (qi != 0) begin
      rx = px; ry = py;
    end else if (px == qx && (py != qy || py == 0)) begin
      ri = 1;
    end else begin
      if (px == qx) begin
        rd = 1;
        s = fm(fm(3 * px * px + 2) * finv(fm(2 * py)));
      end else begin
        s = fm(fm(qy - py) * finv(fm(qx - px)));
      end
      rx = fm(s * s - px - qx);
      ry = fm(s * (px - rx) - py);
    end
  endtask

  // Waits for ready, presents the operands with start, returns #1 after the accept edge.
  task automatic launch(input int pi, px, py, qi, qx, qy);
    for (int i = 0; i < 2000 && !ready; i++) begin
      @(posedge clk); #1;
    end
    P_inf = pi[0]; Px = 8'(px); Py = 8'(py);
    Q_inf = qi[0]; Qx = 8'(qx); Qy = 8'(qy);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts cycles from the start cycle (cycle 0) to the Done cycle.
  task automatic wait_done(output int lat, output bit got);
    got = 1'b0;
    lat = 1;
    for (int i = 0; i < 2000; i++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic watch_no_done(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
  endtask

  initial begin
    int lat, seen, ri, rx, ry, rd, ip, iq, sel, n;
    bit got;

    //            pi px py qi qx qy  ei ex ey ed lat
    vecs[0] = '{0, 5, 1, 0, 5, 1,  0, 6, 3, 1, 0};
    vecs[1] = '{0, 5, 1, 0, 6, 3,  0,10, 6, 0, 0};
    vecs[2] = '{0, 6, 3, 0, 6, 3,  0, 3, 1, 1, 0};
    vecs[3] = '{0, 5, 1, 0, 5,16,  1, 0, 0, 0, 3};
    vecs[4] = '{1, 0, 0, 0, 6, 3,  0, 6, 3, 0, 3};
    vecs[5] = '{1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 3};
    vecs[6] = '{0, 6, 3, 1, 0, 0,  0, 6, 3, 0, 3};
    vecs[7] = '{0,10, 6, 0, 3, 1,  0, 0, 6, 0, 0};

    for (int x = 0; x < 17; x++)
      for (int y = 0; y < 17; y++)
        if (fm(y * y) == fm(x * x * x + 2 * x + 2)) begin
          ptx.push_back(x);
          pty.push_back(y);
        end

    Reset = 1'b1; start = 1'b0; P_inf = 1'b0; Q_inf = 1'b0;
    Px = '0; Py = '0; Qx = '0; Qy = '0;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    chk("reset_ready", ready, 1);
    chk("reset_done", Done, 0);
    chk("reset_rx", Rx, 0);
    chk("reset_ry", Ry, 0);
    chk("reset_rinf", R_inf, 0);
    chk("reset_dbl", dbl, 0);

    // Table runs back-to-back: each job is launched in the previous job's Done cycle.
    foreach (vecs[k]) begin
      launch(vecs[k].pi, vecs[k].px, vecs[k].py, vecs[k].qi, vecs[k].qx, vecs[k].qy);
      wait_done(lat, got);
      if (!got) chk($sformatf("vec%0d_timeout", k), 0, 1);
      else begin
        chk($sformatf("vec%0d_rinf", k), R_inf, vecs[k].ei);
        if (vecs[k].ei == 0) begin
          chk($sformatf("vec%0d_rx", k), Rx, vecs[k].ex);
          chk($sformatf("vec%0d_ry", k), Ry, vecs[k].ey);
        end
        chk($sformatf("vec%0d_dbl", k), dbl, vecs[k].ed);
        if (vecs[k].lat != 0) chk($sformatf("vec%0d_latency", k), lat, vecs[k].lat);
      end
    end
    @(posedge clk); #1;
    chk("done_single_pulse", Done, 0);

    // Reset two cycles into a job aborts it.
    launch(0, 5, 1, 0, 6, 3);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", Done, 0);
    chk("abort_rx", Rx, 0);
    chk("abort_ry", Ry, 0);
    chk("abort_rinf", R_inf, 0);
    chk("abort_dbl", dbl, 0);
    watch_no_done(200, seen);
    chk("abort_no_done", seen, 0);
    launch(0, 5, 1, 0, 6, 3);
    wait_done(lat, got);
    chk("after_abort_got", got, 1);
    chk("after_abort_rx", Rx, 10);
    chk("after_abort_ry", Ry, 6);

    // Start while busy and operand changes after accept are both ignored.
    launch(0, 5, 1, 0, 6, 3);
    chk("busy_ready", ready, 0);
    @(posedge clk); #1;
    start = 1'b1; Px = 8'd6; Py = 8'd3; Qx = 8'd6; Qy = 8'd3; P_inf = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, got);
    chk("busy_got", got, 1);
    chk("busy_rx", Rx, 10);
    chk("busy_ry", Ry, 6);
    chk("busy_dbl", dbl, 0);
    watch_no_done(200, seen);
    chk("busy_not_queued", seen, 0);
    chk("busy_rx_held", Rx, 10);
    chk("busy_ready_idle", ready, 1);

    for (n = 0; n < 500; n++) begin
      int pi, px, py, qi, qx, qy;
      ip = $urandom_range(0, ptx.size());
      iq = $urandom_range(0, ptx.size());
      sel = $urandom_range(0, 3);
      pi = (ip == ptx.size()) ? 1 : 0;
      qi = (iq == ptx.size()) ? 1 : 0;
      px = pi ? $urandom_range(0, 16) : ptx[ip];
      py = pi ? $urandom_range(0, 16) : pty[ip];
      qx = qi ? $urandom_range(0, 16) : ptx[iq];
      qy = qi ? $urandom_range(0, 16) : pty[iq];
      if (!pi && sel == 0) begin qi = 0; qx = px; qy = py; end
      if (!pi && sel == 1) begin qi = 0; qx = px; qy = fm(-py); end
      model(pi, px, py, qi, qx, qy, ri, rx, ry, rd);
      launch(pi, px, py, qi, qx, qy);
      wait_done(lat, got);
      if (!got) chk("rnd_timeout", 0, 1);
      else begin
        chk("rnd_rinf", R_inf, ri);
        if (ri == 0) begin
          chk("rnd_rx", Rx, rx);
          chk("rnd_ry", Ry, ry);
        end
        chk("rnd_dbl", dbl, rd);
      end
      @(posedge clk); #1;
      chk("rnd_done_pulse", Done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
